// File: rtl/morse_pkg.sv
// ---------------------------------------------------------------------------
// morse_pkg
//   Shared definitions for the Morse receive path: FSM state encoding,
//   character code bases, the invalid-character code and symbol encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRESS = 3'd1,
        S_GAP   = 3'd2,
        S_EMIT  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    localparam logic [5:0] CHAR_INVALID = 6'h3F;
    localparam logic [5:0] LETTER_BASE  = 6'd0;   // 'A'
    localparam logic [5:0] DIGIT_BASE   = 6'd26;  // '0'

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int MAX_SYMS = 5;

endpackage

// File: rtl/morse_lut.sv
// ---------------------------------------------------------------------------
// morse_lut
//   Combinational ITU Morse lookup. Symbol i of the pattern lives in
//   morse_bits[i] (first symbol in bit 0), 1 = dash. Bits above morse_len
//   must be zero; anything not a letter or digit maps to CHAR_INVALID.
// Ports
//   morse_len  in  3  number of symbols (0..5)
//   morse_bits in  5  symbol pattern
//   char_code  out 6  0-25 = A-Z, 26-35 = 0-9, 6'h3F = invalid
// ---------------------------------------------------------------------------
module morse_lut
    import morse_pkg::*;
(
    input  logic [2:0] morse_len,
    input  logic [4:0] morse_bits,
    output logic [5:0] char_code
);

    always_comb begin
        char_code = CHAR_INVALID;
        case ({morse_len, morse_bits})
            {3'd2, 5'd2}:  char_code = LETTER_BASE + 6'd0;   // A .-
            {3'd4, 5'd1}:  char_code = LETTER_BASE + 6'd1;   // B -...
            {3'd4, 5'd5}:  char_code = LETTER_BASE + 6'd2;   // C -.-.
            {3'd3, 5'd1}:  char_code = LETTER_BASE + 6'd3;   // D -..
            {3'd1, 5'd0}:  char_code = LETTER_BASE + 6'd4;   // E .
            {3'd4, 5'd4}:  char_code = LETTER_BASE + 6'd5;   // F ..-.
            {3'd3, 5'd3}:  char_code = LETTER_BASE + 6'd6;   // G --.
            {3'd4, 5'd0}:  char_code = LETTER_BASE + 6'd7;   // H ....
            {3'd2, 5'd0}:  char_code = LETTER_BASE + 6'd8;   // I ..
            {3'd4, 5'd14}: char_code = LETTER_BASE + 6'd9;   // J .---
            {3'd3, 5'd5}:  char_code = LETTER_BASE + 6'd10;  // K -.-
            {3'd4, 5'd2}:  char_code = LETTER_BASE + 6'd11;  // L .-..
            {3'd2, 5'd3}:  char_code = LETTER_BASE + 6'd12;  // M --
            {3'd2, 5'd1}:  char_code = LETTER_BASE + 6'd13;  // N -.
            {3'd3, 5'd7}:  char_code = LETTER_BASE + 6'd14;  // O ---
            {3'd4, 5'd6}:  char_code = LETTER_BASE + 6'd15;  // P .--.
            {3'd4, 5'd11}: char_code = LETTER_BASE + 6'd16;  // Q --.-
            {3'd3, 5'd2}:  char_code = LETTER_BASE + 6'd17;  // R .-.
            {3'd3, 5'd0}:  char_code = LETTER_BASE + 6'd18;  // S ...
            {3'd1, 5'd1}:  char_code = LETTER_BASE + 6'd19;  // T -
            {3'd3, 5'd4}:  char_code = LETTER_BASE + 6'd20;  // U ..-
            {3'd4, 5'd8}:  char_code = LETTER_BASE + 6'd21;  // V ...-
            {3'd3, 5'd6}:  char_code = LETTER_BASE + 6'd22;  // W .--
            {3'd4, 5'd9}:  char_code = LETTER_BASE + 6'd23;  // X -..-
            {3'd4, 5'd13}: char_code = LETTER_BASE + 6'd24;  // Y -.--
            {3'd4, 5'd3}:  char_code = LETTER_BASE + 6'd25;  // Z --..
            {3'd5, 5'd31}: char_code = DIGIT_BASE + 6'd0;    // 0 -----
            {3'd5, 5'd30}: char_code = DIGIT_BASE + 6'd1;    // 1 .----
            {3'd5, 5'd28}: char_code = DIGIT_BASE + 6'd2;    // 2 ..---
            {3'd5, 5'd24}: char_code = DIGIT_BASE + 6'd3;    // 3 ...--
            {3'd5, 5'd16}: char_code = DIGIT_BASE + 6'd4;    // 4 ....-
            {3'd5, 5'd0}:  char_code = DIGIT_BASE + 6'd5;    // 5 .....
            {3'd5, 5'd1}:  char_code = DIGIT_BASE + 6'd6;    // 6 -....
            {3'd5, 5'd3}:  char_code = DIGIT_BASE + 6'd7;    // 7 --...
            {3'd5, 5'd7}:  char_code = DIGIT_BASE + 6'd8;    // 8 ---..
            {3'd5, 5'd15}: char_code = DIGIT_BASE + 6'd9;    // 9 ----.
            default:       char_code = CHAR_INVALID;
        endcase
    end

endmodule

// File: rtl/morse_key_decoder.sv
// ---------------------------------------------------------------------------
// morse_key_decoder
//   Times a single telegraph key, classifies presses as dot/dash, groups
//   symbols into a character on an inter-character gap and emits a 6-bit
//   character code plus the raw morse_bits/morse_len pattern.
//   Optional macro MORSE_DEBOUNCE_EN: inserts a 4-tick debounce stage after
//   the synchronizer (default build: no debounce).
// Ports
//   clk         in   1  system clock
//   rst         in   1  synchronous reset, active-low
//   en          in   1  enable; low = synchronous clear to IDLE
//   key_in      in   1  raw key level, 1 = pressed (asynchronous)
//   sym_valid   out  1  pulse: symbol classified
//   sym_dash    out  1  with sym_valid: 1 = dash
//   char_valid  out  1  pulse: char_code/morse_bits/morse_len valid
//   char_code   out  6  0-25 A-Z, 26-35 0-9, 6'h3F invalid
//   morse_bits  out  5  accumulated symbols, first in bit 0
//   morse_len   out  3  symbol count 0..5
//   busy        out  1  state != IDLE
//   long_press  out  1  pulse: abort press reached LONG_TICKS
// ---------------------------------------------------------------------------
module morse_key_decoder
    import morse_pkg::*;
#(
    parameter int TICK_CYCLES = 1_000_000,
    parameter int DASH_TICKS  = 20,
    parameter int GAP_TICKS   = 40,
    parameter int LONG_TICKS  = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       key_in,
    output logic       sym_valid,
    output logic       sym_dash,
    output logic       char_valid,
    output logic [5:0] char_code,
    output logic [4:0] morse_bits,
    output logic [2:0] morse_len,
    output logic       busy,
    output logic       long_press
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int PW = $clog2(LONG_TICKS + 1);
    localparam int GW = $clog2(GAP_TICKS + 1);

    state_t          state;
    logic [1:0]      sync_q;
    logic            key_sync;
    logic            key_s;
    logic            key_d;
    logic            rise;
    logic            fall;
    logic            key_edge;
    logic [TW-1:0]   tick_cnt;
    logic            tick;
    logic [PW-1:0]   press_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            ovf;
    logic            is_dash;
    logic [5:0]      lut_code;

    // Two-flop synchronizer; only reset clears it so that a key held across
    // en toggling does not fabricate an edge.
    always_ff @(posedge clk) begin
        if (!rst) sync_q <= 2'b00;
        else      sync_q <= {sync_q[0], key_in};
    end
    assign key_sync = sync_q[1];

`ifdef MORSE_DEBOUNCE_EN
    // key_s follows key_sync only after it has disagreed for 4 ticks in a
    // row; any return to agreement restarts the count.
    logic [1:0] deb_cnt;
    logic       key_deb;
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            key_deb <= 1'b0;
            deb_cnt <= 2'd0;
        end else if (key_sync == key_deb) begin
            deb_cnt <= 2'd0;
        end else if (tick) begin
            if (deb_cnt == 2'd3) begin
                key_deb <= key_sync;
                deb_cnt <= 2'd0;
            end else begin
                deb_cnt <= deb_cnt + 2'd1;
            end
        end
    end
    assign key_s = key_deb;
`else
    assign key_s = key_sync;
`endif

    always_ff @(posedge clk) begin
        if (!rst) key_d <= 1'b0;
        else      key_d <= key_s;
    end

    assign rise     = key_s & ~key_d;
    assign fall     = ~key_s & key_d;
    assign key_edge = rise | fall;

    // Tick prescaler restarts on every key edge so each press/gap is timed
    // from its own start; no tick is issued in the edge cycle itself.
    assign tick = en && !key_edge && (tick_cnt == TW'(TICK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst || !en)
            tick_cnt <= '0;
        else if (key_edge || tick_cnt == TW'(TICK_CYCLES - 1))
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    assign is_dash = (press_cnt >= PW'(DASH_TICKS));
    assign busy    = (state != S_IDLE);

    morse_lut u_lut (
        .morse_len  (morse_len),
        .morse_bits (morse_bits),
        .char_code  (lut_code)
    );

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            state      <= S_IDLE;
            press_cnt  <= '0;
            gap_cnt    <= '0;
            ovf        <= 1'b0;
            morse_bits <= '0;
            morse_len  <= '0;
            sym_valid  <= 1'b0;
            sym_dash   <= 1'b0;
            char_valid <= 1'b0;
            char_code  <= '0;
            long_press <= 1'b0;
        end else begin
            sym_valid  <= 1'b0;
            char_valid <= 1'b0;
            long_press <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state     <= S_PRESS;
                        press_cnt <= '0;
                    end
                end
                S_PRESS: begin
                    if (fall) begin
                        sym_valid <= 1'b1;
                        sym_dash  <= is_dash ? SYM_DASH : SYM_DOT;
                        // Sixth and later symbols only mark the character bad.
                        if (morse_len == 3'(MAX_SYMS)) begin
                            ovf <= 1'b1;
                        end else begin
                            morse_bits[morse_len] <= is_dash;
                            morse_len             <= morse_len + 3'd1;
                        end
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end else if (tick) begin
                        // Reaching LONG_TICKS leaves PRESS, so the count
                        // never runs past its saturation value.
                        if (press_cnt == PW'(LONG_TICKS - 1)) begin
                            press_cnt  <= PW'(LONG_TICKS);
                            morse_bits <= '0;
                            morse_len  <= '0;
                            ovf        <= 1'b0;
                            long_press <= 1'b1;
                            state      <= S_HOLD;
                        end else begin
                            press_cnt <= press_cnt + PW'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (rise) begin
                        press_cnt <= '0;
                        state     <= S_PRESS;
                    end else if (tick) begin
                        if (gap_cnt == GW'(GAP_TICKS - 1)) begin
                            char_valid <= 1'b1;
                            char_code  <= ovf ? CHAR_INVALID : lut_code;
                            state      <= S_EMIT;
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                end
                S_EMIT: begin
                    // Pattern was held through the char_valid cycle; drop it now.
                    morse_bits <= '0;
                    morse_len  <= '0;
                    ovf        <= 1'b0;
                    char_code  <= '0;
                    gap_cnt    <= '0;
                    state      <= S_IDLE;
                end
                S_HOLD: begin
                    if (fall) begin
                        press_cnt <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_key_decoder.sv
// ---------------------------------------------------------------------------
// tb_morse_key_decoder
//   Directed bench: small timing parameters, key presses sized in ticks,
//   a negedge monitor that tallies pulses and captures emitted characters.
// ---------------------------------------------------------------------------
module tb_morse_key_decoder;

    localparam int TC = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       key_in;
    logic       sym_valid;
    logic       sym_dash;
    logic       char_valid;
    logic [5:0] char_code;
    logic [4:0] morse_bits;
    logic [2:0] morse_len;
    logic       busy;
    logic       long_press;

    morse_key_decoder #(
        .TICK_CYCLES (TC),
        .DASH_TICKS  (3),
        .GAP_TICKS   (5),
        .LONG_TICKS  (12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .key_in     (key_in),
        .sym_valid  (sym_valid),
        .sym_dash   (sym_dash),
        .char_valid (char_valid),
        .char_code  (char_code),
        .morse_bits (morse_bits),
        .morse_len  (morse_len),
        .busy       (busy),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: tallies pulses between clear_mon calls.
    int         sym_cnt;
    int         char_cnt;
    int         long_cnt;
    logic [7:0] dash_mask;
    logic [5:0] cap_code;
    logic [4:0] cap_bits;
    logic [2:0] cap_len;

    always @(negedge clk) begin
        if (sym_valid) begin
            if (sym_cnt < 8) dash_mask[sym_cnt[2:0]] = sym_dash;
            sym_cnt++;
        end
        if (char_valid) begin
            char_cnt++;
            cap_code = char_code;
            cap_bits = morse_bits;
            cap_len  = morse_len;
        end
        if (long_press) long_cnt++;
    end

    task automatic clear_mon();
        sym_cnt   = 0;
        char_cnt  = 0;
        long_cnt  = 0;
        dash_mask = '0;
        cap_code  = '0;
        cap_bits  = '0;
        cap_len   = '0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // 4*t+2 cycles of key level gives exactly t ticks counted.
    task automatic press(input int t);
        key_in = 1'b1;
        cyc(TC * t + 2);
        key_in = 1'b0;
    endtask

    task automatic gap(input int t);
        cyc(TC * t + 2);
    endtask

    task automatic idle();
        cyc(40);
    endtask

    // All outputs packed: busy, sym_valid, sym_dash, char_valid, long_press, code, bits, len
    function automatic logic [31:0] outs();
        return {13'd0, busy, sym_valid, sym_dash, char_valid, long_press, char_code, morse_bits, morse_len};
    endfunction

    initial begin
        rst    = 1'b0;
        en     = 1'b1;
        key_in = 1'b0;
        clear_mon();
        cyc(3);
        chk("reset_outs", outs(), 32'd0);
        rst = 1'b1;
        cyc(2);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // 1: single dot -> 'E'
        clear_mon();
        press(1);
        idle();
        chk("t1_sym_cnt", sym_cnt, 1);
        chk("t1_dash", {24'd0, dash_mask}, 32'h0);
        chk("t1_char_cnt", char_cnt, 1);
        chk("t1_code", {26'd0, cap_code}, 32'd4);
        chk("t1_len", {29'd0, cap_len}, 32'd1);
        chk("t1_cleared", outs(), 32'd0);

        // 2: dot dash -> 'A'
        clear_mon();
        press(1); gap(2); press(4);
        idle();
        chk("t2_sym_cnt", sym_cnt, 2);
        chk("t2_dash", {24'd0, dash_mask}, 32'h2);
        chk("t2_char_cnt", char_cnt, 1);
        chk("t2_code", {26'd0, cap_code}, 32'd0);
        chk("t2_bits", {27'd0, cap_bits}, 32'h02);
        chk("t2_len", {29'd0, cap_len}, 32'd2);

        // 3: five dashes -> '0'; six dashes -> invalid
        clear_mon();
        for (int i = 0; i < 5; i++) begin
            press(4);
            if (i < 4) gap(2);
        end
        idle();
        chk("t3_code", {26'd0, cap_code}, 32'd26);
        chk("t3_bits", {27'd0, cap_bits}, 32'h1F);
        chk("t3_len", {29'd0, cap_len}, 32'd5);
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            press(4);
            if (i < 5) gap(2);
        end
        idle();
        chk("t3_ovf_syms", sym_cnt, 6);
        chk("t3_ovf_char_cnt", char_cnt, 1);
        chk("t3_ovf_code", {26'd0, cap_code}, 32'h3F);
        chk("t3_ovf_len", {29'd0, cap_len}, 32'd5);

        // 4: 3 ticks = dash, 2 ticks = dot, 4-tick gap keeps one char -> 'N'
        clear_mon();
        press(3); gap(4);
        chk("t4_no_char_mid", char_cnt, 0);
        press(2);
        idle();
        chk("t4_sym_cnt", sym_cnt, 2);
        chk("t4_dash", {24'd0, dash_mask}, 32'h1);
        chk("t4_char_cnt", char_cnt, 1);
        chk("t4_code", {26'd0, cap_code}, 32'd13);
        chk("t4_len", {29'd0, cap_len}, 32'd2);

        // 5: dot then a 13-tick press aborts the character
        clear_mon();
        press(1); gap(2);
        key_in = 1'b1;
        cyc(TC * 13 + 2);
        chk("t5_long_cnt", long_cnt, 1);
        chk("t5_busy_hold", {31'd0, busy}, 32'd1);
        chk("t5_len_cleared", {29'd0, morse_len}, 32'd0);
        key_in = 1'b0;
        idle();
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        chk("t5_char_cnt", char_cnt, 0);
        chk("t5_sym_cnt", sym_cnt, 1);

        // 6a: reset during GAP with two symbols held
        clear_mon();
        press(1); gap(2); press(1);
        cyc(10);
        chk("t6a_len_held", {29'd0, morse_len}, 32'd2);
        chk("t6a_busy_held", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        cyc(1);
        chk("t6a_outs", outs(), 32'd0);
        cyc(2);
        rst = 1'b1;
        idle();
        chk("t6a_char_cnt", char_cnt, 0);

        // 6b: en low during GAP with two symbols held
        clear_mon();
        press(4); gap(2); press(1);
        cyc(10);
        chk("t6b_len_held", {29'd0, morse_len}, 32'd2);
        chk("t6b_bits_held", {27'd0, morse_bits}, 32'h01);
        en = 1'b0;
        cyc(1);
        chk("t6b_outs", outs(), 32'd0);
        cyc(2);
        en = 1'b1;
        idle();
        chk("t6b_char_cnt", char_cnt, 0);
        chk("t6b_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
